// File: rtl/vx_raster_prefetch_agent.sv
`default_nettype none
// ============================================================================
//  Module   : vx_raster_prefetch_agent
//  Purpose  : Raster agent for the SFU raster path. Prefetches raster stamp
//             packets from the raster bus into a DEPTH-entry queue so execute
//             requests are decoupled from the bus handshake. Latches the
//             end-of-frame (done) packet and answers every later request from
//             it until frame_start. Drives the raster CSR write port and
//             returns per-lane {pid, ~done} through a 2-entry commit buffer.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i            clock
//    reset_i          asynchronous, active-high reset
//    bus_valid_i      raster bus packet valid
//    bus_stamps_i     per-lane stamp payload           [NUM_LANES*STAMP_W]
//    bus_pids_i       per-lane primitive id            [NUM_LANES*PID_W]
//    bus_done_i       packet is the end-of-frame marker
//    bus_ready_o      packet accepted when bus_valid_i && bus_ready_o
//    exe_valid_i      raster fetch instruction valid
//    exe_meta_i       instruction metadata (passed through)  [META_W]
//    exe_ready_o      instruction consumed this cycle
//    frame_start_i    pulse: release latched done, arm for next frame
//    csr_wr_valid_o   CSR stamp write strobe
//    csr_wr_meta_o    metadata of the CSR write                [META_W]
//    csr_wr_stamps_o  stamps to write                [NUM_LANES*STAMP_W]
//    cmt_valid_o      commit valid
//    cmt_meta_o       committed metadata                       [META_W]
//    cmt_data_o       per-lane result                [NUM_LANES*XLEN]
//    cmt_ready_i      commit accepted
//    queue_count_o    occupied prefetch queue entries
//    perf_stamps_o    non-done responses issued (wraps)
//    perf_stalls_o    cycles with exe_valid_i && !exe_ready_o (wraps)
// ============================================================================
module vx_raster_prefetch_agent #(
    parameter int NUM_LANES = 4,
    parameter int STAMP_W   = 96,
    parameter int PID_W     = 8,
    parameter int META_W    = 96,
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    // raster bus
    input  logic                           bus_valid_i,
    input  logic [NUM_LANES*STAMP_W-1:0]   bus_stamps_i,
    input  logic [NUM_LANES*PID_W-1:0]     bus_pids_i,
    input  logic                           bus_done_i,
    output logic                           bus_ready_o,
    // execute request
    input  logic                           exe_valid_i,
    input  logic [META_W-1:0]              exe_meta_i,
    output logic                           exe_ready_o,
    input  logic                           frame_start_i,
    // CSR write port
    output logic                           csr_wr_valid_o,
    output logic [META_W-1:0]              csr_wr_meta_o,
    output logic [NUM_LANES*STAMP_W-1:0]   csr_wr_stamps_o,
    // commit
    output logic                           cmt_valid_o,
    output logic [META_W-1:0]              cmt_meta_o,
    output logic [NUM_LANES*XLEN-1:0]      cmt_data_o,
    input  logic                           cmt_ready_i,
    // status / performance
    output logic [$clog2(DEPTH+1)-1:0]     queue_count_o,
    output logic [31:0]                    perf_stamps_o,
    output logic [31:0]                    perf_stalls_o
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH+1);
    localparam int C_SW    = NUM_LANES * STAMP_W;
    localparam int C_PW    = NUM_LANES * PID_W;
    localparam int C_DW    = NUM_LANES * XLEN;

    // ------------------------------------------------------------------
    // Prefetch queue storage (no reset needed: occupancy gates every read)
    // ------------------------------------------------------------------
    logic [C_SW-1:0]    q_stamps_q [DEPTH];
    logic [C_PW-1:0]    q_pids_q   [DEPTH];
    logic               q_done_q   [DEPTH];

    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0] count_q,  count_d;
    logic               done_lat_q, done_lat_d;

    // ------------------------------------------------------------------
    // Commit buffer (2-entry elastic FIFO)
    // ------------------------------------------------------------------
    logic [META_W-1:0]  ob_meta_q [2];
    logic [C_DW-1:0]    ob_data_q [2];
    logic               ob_rd_q, ob_rd_d;
    logic               ob_wr_q, ob_wr_d;
    logic [1:0]         ob_count_q, ob_count_d;

    logic [31:0]        perf_stamps_q, perf_stamps_d;
    logic [31:0]        perf_stalls_q, perf_stalls_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_head_done;
    logic [C_SW-1:0]    w_head_stamps;
    logic [C_PW-1:0]    w_head_pids;
    logic               w_obuf_ready;
    logic               w_fire;
    logic               w_pop_exe;
    logic               w_pop_fs;
    logic               w_pop;
    logic               w_ob_pop;
    logic [C_DW-1:0]    w_resp_data;

    assign w_empty       = (count_q == '0);
    assign w_full        = (count_q == C_CNT_W'(DEPTH));
    assign w_head_done   = q_done_q[rd_ptr_q];
    assign w_head_stamps = q_stamps_q[rd_ptr_q];
    assign w_head_pids   = q_pids_q[rd_ptr_q];

    // Nothing is accepted once the done packet is in, until frame_start.
    assign bus_ready_o   = !w_full && !done_lat_q;
    assign w_push        = bus_valid_i && bus_ready_o;

    assign w_obuf_ready  = (ob_count_q != 2'd2);
    assign w_fire        = exe_valid_i && !w_empty && w_obuf_ready && !frame_start_i;

    // A done head is sticky for execute requests; only frame_start drops it.
    assign w_pop_exe     = w_fire && !w_head_done;
    assign w_pop_fs      = frame_start_i && !w_empty && w_head_done;
    assign w_pop         = w_pop_exe || w_pop_fs;

    assign exe_ready_o   = w_fire;

    assign csr_wr_valid_o  = w_pop_exe;
    assign csr_wr_meta_o   = exe_meta_i;
    assign csr_wr_stamps_o = w_head_stamps;

    // Per-lane response word: zero-extended {pid, ~done}
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_resp_data[i*XLEN +: XLEN] =
            XLEN'({w_head_pids[i*PID_W +: PID_W], ~w_head_done});
    end

    // ------------------------------------------------------------------
    // Queue next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q + C_PTR_W'(w_pop);
        wr_ptr_d   = wr_ptr_q + C_PTR_W'(w_push);
        count_d    = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - C_CNT_W'(1);
        end
        // A done packet arriving in the frame_start cycle belongs to the
        // new frame, so the set takes priority over the clear.
        done_lat_d = done_lat_q;
        if (frame_start_i) begin
            done_lat_d = 1'b0;
        end
        if (w_push && bus_done_i) begin
            done_lat_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            done_lat_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            done_lat_q <= done_lat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            q_stamps_q[wr_ptr_q] <= bus_stamps_i;
            q_pids_q[wr_ptr_q]   <= bus_pids_i;
            q_done_q[wr_ptr_q]   <= bus_done_i;
        end
    end

    // ------------------------------------------------------------------
    // Commit buffer next state
    // ------------------------------------------------------------------
    assign w_ob_pop = (ob_count_q != 2'd0) && cmt_ready_i;

    always_comb begin
        ob_rd_d    = ob_rd_q ^ w_ob_pop;
        ob_wr_d    = ob_wr_q ^ w_fire;
        ob_count_d = ob_count_q + 2'(w_fire) - 2'(w_ob_pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ob_rd_q    <= 1'b0;
            ob_wr_q    <= 1'b0;
            ob_count_q <= 2'd0;
        end else begin
            ob_rd_q    <= ob_rd_d;
            ob_wr_q    <= ob_wr_d;
            ob_count_q <= ob_count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fire) begin
            ob_meta_q[ob_wr_q] <= exe_meta_i;
            ob_data_q[ob_wr_q] <= w_resp_data;
        end
    end

    assign cmt_valid_o = (ob_count_q != 2'd0);
    assign cmt_meta_o  = ob_meta_q[ob_rd_q];
    assign cmt_data_o  = ob_data_q[ob_rd_q];

    // ------------------------------------------------------------------
    // Performance counters (wrap modulo 2^32)
    // ------------------------------------------------------------------
    always_comb begin
        perf_stamps_d = perf_stamps_q + 32'(w_pop_exe);
        perf_stalls_d = perf_stalls_q + 32'(exe_valid_i && !w_fire);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_stamps_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_stamps_q <= perf_stamps_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign queue_count_o = count_q;
    assign perf_stamps_o = perf_stamps_q;
    assign perf_stalls_o = perf_stalls_q;

endmodule

`default_nettype wire

// File: tb/tb_vx_raster_prefetch_agent.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_raster_prefetch_agent
//  Purpose  : Self-checking bench for vx_raster_prefetch_agent. A queue-based
//             model predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vx_raster_prefetch_agent;

    localparam int NL = 4;
    localparam int SW = 96;
    localparam int PW = 8;
    localparam int MW = 96;
    localparam int XL = 32;
    localparam int DP = 4;
    localparam int CW = $clog2(DP+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              bus_valid;
    logic [NL*SW-1:0]  bus_stamps;
    logic [NL*PW-1:0]  bus_pids;
    logic              bus_done;
    logic              bus_ready;
    logic              exe_valid;
    logic [MW-1:0]     exe_meta;
    logic              exe_ready;
    logic              frame_start;
    logic              csr_wr_valid;
    logic [MW-1:0]     csr_wr_meta;
    logic [NL*SW-1:0]  csr_wr_stamps;
    logic              cmt_valid;
    logic [MW-1:0]     cmt_meta;
    logic [NL*XL-1:0]  cmt_data;
    logic              cmt_ready;
    logic [CW-1:0]     queue_count;
    logic [31:0]       perf_stamps;
    logic [31:0]       perf_stalls;

    always #5 clk = ~clk;

    vx_raster_prefetch_agent #(
        .NUM_LANES(NL), .STAMP_W(SW), .PID_W(PW), .META_W(MW), .XLEN(XL), .DEPTH(DP)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .bus_valid_i    (bus_valid),
        .bus_stamps_i   (bus_stamps),
        .bus_pids_i     (bus_pids),
        .bus_done_i     (bus_done),
        .bus_ready_o    (bus_ready),
        .exe_valid_i    (exe_valid),
        .exe_meta_i     (exe_meta),
        .exe_ready_o    (exe_ready),
        .frame_start_i  (frame_start),
        .csr_wr_valid_o (csr_wr_valid),
        .csr_wr_meta_o  (csr_wr_meta),
        .csr_wr_stamps_o(csr_wr_stamps),
        .cmt_valid_o    (cmt_valid),
        .cmt_meta_o     (cmt_meta),
        .cmt_data_o     (cmt_data),
        .cmt_ready_i    (cmt_ready),
        .queue_count_o  (queue_count),
        .perf_stamps_o  (perf_stamps),
        .perf_stalls_o  (perf_stalls)
    );

    // ------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [NL*SW-1:0] st;
        logic [NL*PW-1:0] pd;
        logic             dn;
    } pkt_t;

    typedef struct {
        logic [MW-1:0]    meta;
        logic [NL*XL-1:0] data;
    } rsp_t;

    pkt_t        pq[$];
    rsp_t        cq[$];
    bit          m_done;
    int unsigned m_stamps;
    int unsigned m_stalls;

    int          n_pass  = 0;
    int          n_total = 0;
    int          lane0_log[$];
    int          csr_cnt = 0;
    int unsigned stall_snap;
    int          meta_seq = 0;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NL*SW-1:0] mk_stamps(input int base);
        logic [NL*SW-1:0] s;
        for (int i = 0; i < NL; i++) s[i*SW +: SW] = {3{32'hC0DE0000 ^ 32'(base*16 + i)}};
        return s;
    endfunction

    function automatic logic [NL*PW-1:0] mk_pids(input int base);
        logic [NL*PW-1:0] p;
        for (int i = 0; i < NL; i++) p[i*PW +: PW] = 8'(base + i);
        return p;
    endfunction

    task automatic set_bus(input bit v, input int pid, input bit dn);
        bus_valid  = v;
        bus_pids   = mk_pids(pid);
        bus_stamps = mk_stamps(pid);
        bus_done   = dn;
    endtask

    task automatic next_meta();
        meta_seq++;
        exe_meta = {32'hE0E0_0000, 32'h0, 32'(meta_seq)};
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle-by-cycle compare against the model, sampled on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin : cmp
        bit   ebr;
        bit   ef;
        pkt_t np;
        rsp_t r;
        if (reset) begin
            chk("rst_bus_ready", bus_ready, 1'b1);
            chk("rst_exe_ready", exe_ready, 1'b0);
            chk("rst_csr_valid", csr_wr_valid, 1'b0);
            chk("rst_cmt_valid", cmt_valid, 1'b0);
            chk("rst_queue_count", queue_count, '0);
            chk("rst_perf_stamps", perf_stamps, '0);
            chk("rst_perf_stalls", perf_stalls, '0);
            pq.delete();
            cq.delete();
            m_done   = 1'b0;
            m_stamps = 0;
            m_stalls = 0;
        end else begin
            ebr = (pq.size() < DP) && !m_done;
            ef  = exe_valid && (pq.size() > 0) && (cq.size() < 2) && !frame_start;
            chk("bus_ready", bus_ready, ebr);
            chk("exe_ready", exe_ready, ef);
            chk("queue_count", queue_count, pq.size());
            chk("perf_stamps", perf_stamps, m_stamps);
            chk("perf_stalls", perf_stalls, m_stalls);
            chk("cmt_valid", cmt_valid, cq.size() > 0);
            if (cq.size() > 0) begin
                chk("cmt_meta", cmt_meta, cq[0].meta);
                chk("cmt_data", cmt_data, cq[0].data);
            end
            if (ef) begin
                chk("csr_valid", csr_wr_valid, !pq[0].dn);
                if (!pq[0].dn) begin
                    chk("csr_meta", csr_wr_meta, exe_meta);
                    chk("csr_stamps", csr_wr_stamps, pq[0].st);
                end
            end else begin
                chk("csr_valid", csr_wr_valid, 1'b0);
            end

            if (cmt_valid && cmt_ready) lane0_log.push_back(int'(cmt_data[XL-1:0]));
            if (csr_wr_valid) csr_cnt++;

            // advance the model by one clock
            if (cq.size() > 0 && cmt_ready) void'(cq.pop_front());
            if (ef) begin
                r.meta = exe_meta;
                for (int i = 0; i < NL; i++)
                    r.data[i*XL +: XL] = 32'(pq[0].pd[i*PW +: PW]) * 2 + (pq[0].dn ? 0 : 1);
                cq.push_back(r);
                if (!pq[0].dn) begin
                    void'(pq.pop_front());
                    m_stamps++;
                end
            end else if (frame_start && pq.size() > 0) begin
                if (pq[0].dn) void'(pq.pop_front());
            end
            if (exe_valid && !ef) m_stalls++;
            if (frame_start) m_done = 1'b0;
            if (bus_valid && ebr) begin
                np.st = bus_stamps;
                np.pd = bus_pids;
                np.dn = bus_done;
                pq.push_back(np);
                if (bus_done) m_done = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        reset       = 1'b1;
        set_bus(1'b0, 0, 1'b0);
        exe_valid   = 1'b0;
        exe_meta    = '0;
        frame_start = 1'b0;
        cmt_ready   = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // T1: three packets, then three requests
        lane0_log.delete();
        csr_cnt   = 0;
        cmt_ready = 1'b1;
        set_bus(1'b1, 5, 1'b0); step(1);
        set_bus(1'b1, 6, 1'b0); step(1);
        set_bus(1'b1, 7, 1'b0); step(1);
        bus_valid = 1'b0;
        exe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_meta();
            step(1);
        end
        exe_valid = 1'b0;
        step(3);
        chk("t1_ncommit", lane0_log.size(), 3);
        chk("t1_lane0_a", lane0_log[0], 'hB);
        chk("t1_lane0_b", lane0_log[1], 'hD);
        chk("t1_lane0_c", lane0_log[2], 'hF);
        chk("t1_csr_pulses", csr_cnt, 3);
        chk("t1_perf_stamps", perf_stamps, 3);

        // T2: fill the queue, then free one slot
        lane0_log.delete();
        for (int k = 0; k < 4; k++) begin
            set_bus(1'b1, 'h10 + k, 1'b0);
            step(1);
        end
        set_bus(1'b1, 'h14, 1'b0);
        step(2);
        chk("t2_full_count", queue_count, 4);
        @(negedge clk);
        chk("t2_full_bus_ready", bus_ready, 1'b0);
        next_meta();
        exe_valid = 1'b1;
        step(1);
        exe_valid = 1'b0;
        @(negedge clk);
        chk("t2_slot_bus_ready", bus_ready, 1'b1);
        step(1);
        bus_valid = 1'b0;
        chk("t2_refill_count", queue_count, 4);
        exe_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_meta();
            step(1);
        end
        exe_valid = 1'b0;
        step(3);
        chk("t2_drained", queue_count, 0);
        chk("t2_ncommit", lane0_log.size(), 5);
        chk("t2_lane0_first", lane0_log[0], 'h21);
        chk("t2_lane0_last", lane0_log[4], 'h29);

        // T3: packet then done packet; done answers are sticky
        lane0_log.delete();
        csr_cnt = 0;
        set_bus(1'b1, 9, 1'b0); step(1);
        set_bus(1'b1, 3, 1'b1); step(1);
        set_bus(1'b1, 'h40, 1'b0);
        exe_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_meta();
            step(1);
        end
        exe_valid = 1'b0;
        step(3);
        chk("t3_count", queue_count, 1);
        @(negedge clk);
        chk("t3_bus_ready", bus_ready, 1'b0);
        chk("t3_ncommit", lane0_log.size(), 3);
        chk("t3_lane0_a", lane0_log[0], 'h13);
        chk("t3_lane0_b", lane0_log[1], 'h06);
        chk("t3_lane0_c", lane0_log[2], 'h06);
        chk("t3_csr_pulses", csr_cnt, 1);

        // T4: frame_start together with a request on a sticky done head
        step(1);
        lane0_log.delete();
        bus_valid   = 1'b0;
        next_meta();
        exe_valid   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        chk("t4_fs_blocks_fire", exe_ready, 1'b0);
        step(1);
        frame_start = 1'b0;
        chk("t4_count", queue_count, 0);
        @(negedge clk);
        chk("t4_bus_ready", bus_ready, 1'b1);
        chk("t4_empty_stall", exe_ready, 1'b0);
        step(2);
        set_bus(1'b1, 'h21, 1'b0);
        step(1);
        bus_valid = 1'b0;
        @(negedge clk);
        chk("t4_new_fire", exe_ready, 1'b1);
        step(1);
        exe_valid = 1'b0;
        step(3);
        chk("t4_ncommit", lane0_log.size(), 1);
        chk("t4_lane0", lane0_log[0], 'h43);

        // T5: commit back-pressure, then in-order drain
        lane0_log.delete();
        cmt_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_bus(1'b1, 'h30 + k, 1'b0);
            step(1);
        end
        bus_valid  = 1'b0;
        stall_snap = m_stalls;
        exe_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_meta();
            step(1);
        end
        exe_valid = 1'b0;
        chk("t5_count_held", queue_count, 2);
        chk("t5_model_stalls", m_stalls - stall_snap, 4);
        @(negedge clk);
        chk("t5_cmt_valid_held", cmt_valid, 1'b1);
        step(1);
        cmt_ready = 1'b1;
        exe_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_meta();
            step(1);
        end
        exe_valid = 1'b0;
        step(4);
        chk("t5_ncommit", lane0_log.size(), 4);
        chk("t5_lane0_a", lane0_log[0], 'h61);
        chk("t5_lane0_b", lane0_log[1], 'h63);
        chk("t5_lane0_c", lane0_log[2], 'h65);
        chk("t5_lane0_d", lane0_log[3], 'h67);
        chk("t5_drained", queue_count, 0);

        // T6: asynchronous reset mid-operation
        cmt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_bus(1'b1, 'h50 + k, 1'b0);
            step(1);
        end
        bus_valid = 1'b0;
        next_meta();
        exe_valid = 1'b1;
        step(1);
        exe_valid = 1'b0;
        @(negedge clk);
        chk("t6_pre_cmt_valid", cmt_valid, 1'b1);
        chk("t6_pre_count", queue_count, 2);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_async_cmt_valid", cmt_valid, 1'b0);
        chk("t6_async_count", queue_count, 0);
        chk("t6_async_bus_ready", bus_ready, 1'b1);
        chk("t6_async_csr", csr_wr_valid, 1'b0);
        chk("t6_async_perf_stamps", perf_stamps, 0);
        step(2);
        reset     = 1'b0;
        cmt_ready = 1'b1;
        lane0_log.delete();
        csr_cnt   = 0;
        exe_valid = 1'b1;
        step(4);
        exe_valid = 1'b0;
        step(2);
        chk("t6_post_count", queue_count, 0);
        chk("t6_post_ncommit", lane0_log.size(), 0);
        chk("t6_post_csr", csr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule

`default_nettype wire
